// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache with AXI read refill.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
`default_nettype none

module icache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_ena,
    input  logic        flush,
    input  logic        invalidate,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic        s_rvalid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    input  logic        m_rlast,
    output logic        m_rready
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WOFF_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int VW     = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_t;
    state_t state, state_nx;

    logic [31:0]              req_addr;
    logic                     req_cached;
    logic [VW-1:0]            victim;
    logic [WOFF_W-1:0]        beat_cnt;
    logic [31:0]              cap;
    logic                     flushed;
    logic                     inv_pend;
    logic [WAYS-1:0][SETS-1:0] valid;
    logic [VW-1:0]            ptr_sel;
    logic [VW-1:0]            vict_sel;
    logic [TAG_W-1:0]         rd_tag  [WAYS];
    logic [31:0]              rd_data [WAYS];
    logic [WAYS-1:0]          hit_vec;
    logic                     hit;
    logic [31:0]              hit_word;
    logic                     found;
    logic                     ready;
    logic                     accept;
    logic                     do_inv;
    logic                     beat_we;
    logic                     fill_done;

    wire [IDX_W-1:0]  s_idx    = s_araddr[OFF_W+IDX_W-1:OFF_W];
    wire [WOFF_W-1:0] s_woff   = s_araddr[OFF_W-1:2];
    wire [IDX_W-1:0]  req_idx  = req_addr[OFF_W+IDX_W-1:OFF_W];
    wire [WOFF_W-1:0] req_woff = req_addr[OFF_W-1:2];
    wire [TAG_W-1:0]  req_tag  = req_addr[31:OFF_W+IDX_W];
    wire              unused_bits = ^{s_araddr[1:0]};

    assign accept    = s_arvalid && ready;
    assign do_inv    = (state == IDLE) && (invalidate || inv_pend);
    assign beat_we   = (state == REFILL) && m_rvalid && req_cached;
    assign fill_done = beat_we && m_rlast;
    assign s_arready = ready && rst;
    assign m_arvalid = (state == MISS_REQ);
    assign m_rready  = (state == REFILL);
    assign m_araddr  = req_cached ? {req_addr[31:OFF_W], {OFF_W{1'b0}}} : req_addr;
    assign m_arlen   = req_cached ? 8'(LINE_WORDS - 1) : 8'd0;

    // Arrays are read on the accept edge, so lookup data is ready in LOOKUP.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [TAG_W-1:0] tag_mem  [SETS];
        logic [31:0]      data_mem [SETS*LINE_WORDS];
        logic [TAG_W-1:0] tag_q;
        logic [31:0]      data_q;

        always_ff @(posedge clk) begin
            if (accept) begin
                tag_q  <= tag_mem[s_idx];
                data_q <= data_mem[{s_idx, s_woff}];
            end
            if (beat_we && victim == VW'(w))
                data_mem[{req_idx, beat_cnt}] <= m_rdata;
            if (fill_done && victim == VW'(w))
                tag_mem[req_idx] <= req_tag;
        end
        assign rd_tag[w]  = tag_q;
        assign rd_data[w] = data_q;
    end

    if (WAYS > 1) begin : g_ptr
        logic [SETS-1:0][VW-1:0] ptr;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                ptr <= '0;
            else if (do_inv)
                ptr <= '0;
            else if (fill_done)
                ptr[req_idx] <= ptr[req_idx] + 1'b1;
        end
        assign ptr_sel = ptr[req_idx];
    end else begin : g_dm
        assign ptr_sel = '0;
    end

    always_comb begin
        hit_vec  = '0;
        hit_word = '0;
        vict_sel = ptr_sel;
        found    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid[w][req_idx] && (rd_tag[w] == req_tag);
            if (hit_vec[w])
                hit_word = hit_word | rd_data[w];
            if (!found && !valid[w][req_idx]) begin
                vict_sel = VW'(w);
                found    = 1'b1;
            end
        end
        hit = |hit_vec;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = hit_word;
        case (state)
            IDLE: begin
                ready = !do_inv;
                if (s_arvalid && !do_inv)
                    state_nx = cache_ena ? LOOKUP : MISS_REQ;
            end
            LOOKUP: begin
                if (flush)
                    state_nx = IDLE;
                else if (hit) begin
                    s_rvalid = 1'b1;
                    ready    = !invalidate && !inv_pend;
                    if (s_arvalid && ready)
                        state_nx = cache_ena ? LOOKUP : MISS_REQ;
                    else
                        state_nx = IDLE;
                end else
                    state_nx = MISS_REQ;
            end
            MISS_REQ: if (m_arready) state_nx = REFILL;
            REFILL:   if (m_rvalid && m_rlast) state_nx = RESP;
            RESP: begin
                s_rvalid = !flushed && !flush;
                s_rdata  = cap;
                state_nx = IDLE;
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_cached <= 1'b0;
            victim     <= '0;
            beat_cnt   <= '0;
            cap        <= '0;
            flushed    <= 1'b0;
            inv_pend   <= 1'b0;
            valid      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                req_addr   <= s_araddr;
                req_cached <= cache_ena;
                beat_cnt   <= '0;
                flushed    <= 1'b0;
            end
            if (state == LOOKUP && !hit && !flush)
                victim <= vict_sel;
            if (state == REFILL && m_rvalid) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (!req_cached || beat_cnt == req_woff)
                    cap <= m_rdata;
            end
            if (flush && (state == MISS_REQ || state == REFILL))
                flushed <= 1'b1;
            // Invalidate requests outside IDLE wait until the cache is quiet.
            if (do_inv)
                inv_pend <= 1'b0;
            else if (invalidate && state != IDLE)
                inv_pend <= 1'b1;
            if (do_inv)
                valid <= '0;
            else if (fill_done)
                for (int w = 0; w < WAYS; w++)
                    if (victim == VW'(w))
                        valid[w][req_idx] <= 1'b1;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP && !flush) begin
            if (hit)
                hit_cnt <= hit_cnt + 1'b1;
            else
                miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_nway.sv
// tb_icache_nway: table-driven directed bench for icache_nway (default geometry).
`default_nettype none

module tb_icache_nway;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cache_ena = 1'b0, flush = 1'b0, invalidate = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_rvalid = 1'b0, m_rlast = 1'b0;
    logic        m_rready;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_nway dut (
        .clk(clk), .rst(rst), .cache_ena(cache_ena), .flush(flush),
        .invalidate(invalidate), .s_araddr(s_araddr), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .m_rlast(m_rlast), .m_rready(m_rready)
`ifdef ICACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        cached;
        logic [31:0] base;
        logic        inv;
        logic        fl;
        logic        exp_miss;
        logic [31:0] exp_araddr;
        logic [7:0]  exp_len;
        logic        exp_rv;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [14];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one read and plays an AXI slave returning base+k on beat k.
    task automatic do_read(input logic [31:0] a, input logic c, input logic [31:0] base,
                           input logic inv, input logic fl,
                           output logic missed, output logic [31:0] ga, output logic [7:0] gl,
                           output logic rv, output logic [31:0] gd);
        int n;
        missed = 1'b0; ga = '0; gl = '0; rv = 1'b0; gd = '0;
        s_araddr = a; cache_ena = c; s_arvalid = 1'b1; invalidate = inv;
        #1;
        if (inv) begin
            chk("arready_during_invalidate", 32'(s_arready), 32'd0);
            tick();
            invalidate = 1'b0;
            #1;
        end
        n = 0;
        while (!s_arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        s_arvalid = 1'b0;
        #1;
        for (int cyc = 0; cyc < 20 && !rv; cyc++) begin
            if (s_rvalid) begin
                rv = 1'b1;
                gd = s_rdata;
            end else if (m_arvalid && !missed) begin
                missed = 1'b1; ga = m_araddr; gl = m_arlen;
                m_arready = 1'b1;
                tick();
                m_arready = 1'b0;
                for (int k = 0; k <= int'(gl); k++) begin
                    m_rvalid = 1'b1;
                    m_rdata  = base + 32'(k);
                    m_rlast  = (k == int'(gl));
                    flush    = fl && (k == 0);
                    tick();
                end
                m_rvalid = 1'b0; m_rlast = 1'b0; flush = 1'b0;
                #1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic run_vec(input int i);
        logic missed, rv;
        logic [31:0] ga, gd;
        logic [7:0] gl;
        do_read(tbl[i].addr, tbl[i].cached, tbl[i].base, tbl[i].inv, tbl[i].fl,
                missed, ga, gl, rv, gd);
        chk($sformatf("v%0d_miss", i), 32'(missed), 32'(tbl[i].exp_miss));
        if (tbl[i].exp_miss) begin
            chk($sformatf("v%0d_araddr", i), ga, tbl[i].exp_araddr);
            chk($sformatf("v%0d_arlen", i), 32'(gl), 32'(tbl[i].exp_len));
        end
        chk($sformatf("v%0d_rvalid", i), 32'(rv), 32'(tbl[i].exp_rv));
        if (tbl[i].exp_rv)
            chk($sformatf("v%0d_rdata", i), gd, tbl[i].exp_data);
    endtask

    initial begin
        int n;
        logic missed, rv;
        logic [31:0] ga, gd;
        logic [7:0] gl;

        //            addr          c  base        inv fl miss araddr        len  rv data
        tbl[0]  = '{32'h1FC0_0004, 1, 32'hA0,  0, 0, 1, 32'h1FC0_0000, 8'd7, 1, 32'hA1};
        tbl[1]  = '{32'h1FC0_0008, 1, 32'h0,   0, 0, 0, 32'h0,         8'd0, 1, 32'hA2};
        tbl[2]  = '{32'h1FC0_000C, 1, 32'h0,   0, 0, 0, 32'h0,         8'd0, 1, 32'hA3};
        tbl[3]  = '{32'h0000_10A0, 1, 32'h100, 0, 0, 1, 32'h0000_10A0, 8'd7, 1, 32'h100};
        tbl[4]  = '{32'h0000_20A4, 1, 32'h200, 0, 0, 1, 32'h0000_20A0, 8'd7, 1, 32'h201};
        tbl[5]  = '{32'h0000_30A8, 1, 32'h300, 0, 0, 1, 32'h0000_30A0, 8'd7, 1, 32'h302};
        tbl[6]  = '{32'h0000_20AC, 1, 32'h0,   0, 0, 0, 32'h0,         8'd0, 1, 32'h203};
        tbl[7]  = '{32'h0000_10A0, 1, 32'h110, 0, 0, 1, 32'h0000_10A0, 8'd7, 1, 32'h110};
        tbl[8]  = '{32'h0000_30A8, 1, 32'h0,   0, 0, 0, 32'h0,         8'd0, 1, 32'h302};
        tbl[9]  = '{32'hBFAF_8010, 0, 32'h55,  0, 0, 1, 32'hBFAF_8010, 8'd0, 1, 32'h55};
        tbl[10] = '{32'hBFAF_8010, 0, 32'h56,  0, 0, 1, 32'hBFAF_8010, 8'd0, 1, 32'h56};
        tbl[11] = '{32'h0040_0010, 1, 32'h40,  0, 1, 1, 32'h0040_0000, 8'd7, 0, 32'h0};
        tbl[12] = '{32'h0040_0014, 1, 32'h0,   0, 0, 0, 32'h0,         8'd0, 1, 32'h45};
        tbl[13] = '{32'h1FC0_0004, 1, 32'hB0,  1, 0, 1, 32'h1FC0_0000, 8'd7, 1, 32'hB1};

        // Outputs held quiet while reset is asserted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_rvalid",  32'(s_rvalid),  32'd0);
        chk("rst_arvalid", 32'(m_arvalid), 32'd0);
        chk("rst_rready",  32'(m_rready),  32'd0);
        rst = 1'b1;
        tick();
        chk("idle_arready", 32'(s_arready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            run_vec(i);
            if (i == 0) begin
                // Back-to-back hits: responses on consecutive cycles, no AXI traffic.
                tick();
                s_araddr = 32'h1FC0_0008; cache_ena = 1'b1; s_arvalid = 1'b1;
                #1;
                chk("b2b_idle_arready", 32'(s_arready), 32'd1);
                tick();
                s_araddr = 32'h1FC0_000C;
                #1;
                chk("b2b_rvalid0", 32'(s_rvalid), 32'd1);
                chk("b2b_rdata0", s_rdata, 32'hA2);
                chk("b2b_arready0", 32'(s_arready), 32'd1);
                tick();
                s_arvalid = 1'b0;
                #1;
                chk("b2b_rvalid1", 32'(s_rvalid), 32'd1);
                chk("b2b_rdata1", s_rdata, 32'hA3);
                chk("b2b_arvalid", 32'(m_arvalid), 32'd0);
                tick();
                chk("b2b_done_rvalid", 32'(s_rvalid), 32'd0);
            end
        end

        // Flush during a hitting lookup: no response, back to IDLE.
        tick();
        s_araddr = 32'h1FC0_0008; cache_ena = 1'b1; s_arvalid = 1'b1;
        #1;
        tick();
        s_arvalid = 1'b0; flush = 1'b1;
        #1;
        chk("flush_hit_rvalid", 32'(s_rvalid), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_hit_idle", 32'(s_arready), 32'd1);

        // Flush during a missing lookup: no refill is issued.
        s_araddr = 32'h0080_0000; s_arvalid = 1'b1;
        #1;
        tick();
        s_arvalid = 1'b0; flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (m_arvalid) n++;
            tick();
        end
        chk("flush_miss_no_axi", 32'(n), 32'd0);

`ifdef ICACHE_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, 32'd7);
        chk("miss_cnt", miss_cnt, 32'd7);
`endif

        // Reset in the middle of a refill: the line must not become valid.
        s_araddr = 32'h00C0_0000; cache_ena = 1'b1; s_arvalid = 1'b1;
        #1;
        tick();
        s_arvalid = 1'b0;
        n = 0;
        while (!m_arvalid && n < 10) begin
            tick();
            n++;
        end
        chk("midrst_arvalid", 32'(m_arvalid), 32'd1);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1; m_rlast = 1'b0;
        tick();
        tick();
        m_rvalid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_rready", 32'(m_rready), 32'd0);
        chk("midrst_arready", 32'(s_arready), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        do_read(32'h00C0_0004, 1'b1, 32'h70, 1'b0, 1'b0, missed, ga, gl, rv, gd);
        chk("midrst_remiss", 32'(missed), 32'd1);
        chk("midrst_rdata", gd, 32'h71);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 WAYS, 2, associativity; legal 1, 2, 4.
REQ-002 SETS, 128, sets per way; power of 2, 16..256.
REQ-003 LINE_WORDS, 8, 32-bit words per line; legal 4, 8, 16.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cache_ena  in  1  1 = cached access; sampled with the request.
REQ-007 flush  in  1  discard outstanding response.
REQ-008 invalidate  in  1  clear all valid bits.
REQ-009 s_araddr  in  32  CPU fetch address, word aligned.
REQ-010 s_arvalid  in  1  CPU request.
REQ-011 s_arready  out  1  request accepted when s_arvalid&&s_arready.
REQ-012 s_rdata  out  32  fetched word; s_rvalid  out  1  one-cycle response pulse.
REQ-013 m_araddr  out  32;  m_arlen  out  8;  m_arvalid  out  1;  m_arready  in  1  AXI read address channel (INCR, 4-byte beats).
REQ-014 m_rdata  in  32;  m_rvalid  in  1;  m_rlast  in  1;  m_rready  out  1  AXI read data channel.

Function
REQ-015 Address split: offset = log2(LINE_WORDS)+2 bits, index = log2(SETS) bits, tag = the remainder.
REQ-016 Tag and data storage: synchronous-read arrays; valid bits and per-set replacement pointers: flops.
REQ-017 States: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
REQ-018 s_arready = 1 in IDLE, and in LOOKUP on a cached hit; 0 otherwise and during an invalidate cycle.
REQ-019 Request accepted at edge T: LOOKUP during T+1.
REQ-020 Cached hit in LOOKUP: s_rvalid=1 and s_rdata = hit-way word in that cycle; back-to-back hits sustain one per cycle.
REQ-021 Cached miss in LOOKUP: go to MISS_REQ.
  - m_araddr = line-aligned address; m_arlen = LINE_WORDS-1.
  - Victim: first invalid way (lowest index); else the set's round-robin pointer.
REQ-022 Uncached request (cache_ena=0): skip lookup, go to MISS_REQ.
  - m_araddr = exact address; m_arlen = 0.
  - No allocation; no state update.
REQ-023 MISS_REQ: m_arvalid held at 1 until m_arready; then REFILL. m_araddr and m_arlen are stable while m_arvalid=1.
REQ-024 m_rready = 1 in REFILL only.
REQ-025 REFILL, cached: beat k is written to victim word k; the beat whose k equals the request word offset is captured.
REQ-026 REFILL, uncached: the single beat is captured.
REQ-027 On m_rvalid&&m_rlast: go to RESP. For cached requests, on the same edge:
  - write the victim tag;
  - set its valid bit;
  - advance the set pointer modulo WAYS.
REQ-028 RESP: one cycle, s_rvalid=1, s_rdata = captured word; then IDLE.
REQ-029 m_rlast arriving before LINE_WORDS beats: line is written as received, valid still set (slave error; no recovery).
REQ-030 flush in LOOKUP:
  - suppress s_rvalid and return to IDLE;
  - a miss in that cycle issues no refill.
REQ-031 flush in MISS_REQ or REFILL: burst completes and the line is allocated; RESP suppresses s_rvalid.
REQ-032 invalidate in IDLE:
  - clears all valid bits and replacement pointers in one cycle;
  - s_arready=0 that cycle.
  - In other states it is held pending and performed on the next IDLE.
REQ-033 Same-cycle invalidate and s_arvalid in IDLE: invalidate wins; the request is not accepted.
REQ-034 WAYS=1: direct-mapped; pointer logic absent.

Reset
REQ-035 rst low, asynchronously:
  - state=IDLE;
  - all valid bits and pointers 0;
  - s_rvalid=0, m_arvalid=0, m_rready=0, s_arready=0 while asserted;
  - counters 0.
REQ-036 Reset mid-refill abandons the burst; no line becomes valid.
REQ-037 Array contents are not reset.

Configuration
REQ-038 Macro ICACHE_PERF_CNT_EN defined:
  - adds outputs hit_cnt and miss_cnt, 32 bits each;
  - increment on each cached hit / cached miss in LOOKUP (flushed lookups excluded);
  - wrap at 2^32.
REQ-039 Macro absent: those ports and counters do not exist; all other behaviour is identical.

Verification
REQ-040 Cold read 0x1FC0_0004, cache_ena=1 -> m_araddr=0x1FC0_0000, m_arlen=7; beats 0..7 = 0xA0..0xA7 -> RESP s_rdata=0xA1.
REQ-041 Reads 0x1FC0_0008 then 0x1FC0_000C after fill -> s_rvalid on consecutive cycles, data 0xA2, 0xA3, no AXI traffic.
REQ-042 WAYS=2: fill tags 0x1, 0x2, 0x3 at index 5 -> third fill evicts way 0; tag 0x2 still hits, tag 0x1 misses.
REQ-043 Uncached read 0xBFAF_8010 -> m_araddr=0xBFAF_8010, m_arlen=0; single beat 0x55 -> s_rdata=0x55; a repeat read misses again.
REQ-044 flush asserted during REFILL -> no s_rvalid; a following read of the same line hits.
REQ-045 invalidate pulse after fills -> the next read of 0x1FC0_0004 misses; with ICACHE_PERF_CNT_EN, hit_cnt/miss_cnt match the scenario totals.
